// File: rtl/ftdi_order_decoder_if.sv
// Host-frame decoder bus: FTDI read FIFO side, readback back-pressure, register strobes, status.
interface ftdi_order_decoder_if #(
    parameter int unsigned ADDR_W = 8
);
    logic [7:0]        ri_data;
    logic              ri_empty;
    logic              ri_read;
    logic              rb_full;
    logic [ADDR_W-1:0] address;
    logic [7:0]        value;
    logic              write;
    logic              read;
    logic              busy;
    logic [3:0]        state;
    logic [7:0]        err_count;
    logic              timeout_err;

    modport master (
        input  ri_data, ri_empty, rb_full,
        output ri_read, address, value, write, read, busy, state, err_count, timeout_err
    );

    modport slave (
        output ri_data, ri_empty, rb_full,
        input  ri_read, address, value, write, read, busy, state, err_count, timeout_err
    );
endinterface

// File: rtl/ftdi_order_decoder.sv
// Parses FTDI host frames (header, address, length, payload) into register-file strobes.
// Optional in-frame idle abort is enabled with `define ORDER_DECODER_CMD_TIMEOUT_EN.
module ftdi_order_decoder #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned LEN_W       = 16,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input logic                  clk,
    input logic                  res_n,
    ftdi_order_decoder_if.master bus
);

    typedef enum logic [3:0] {
        StIdle   = 4'd0,
        StAddr   = 4'd1,
        StLen    = 4'd2,
        StWdata  = 4'd3,
        StRissue = 4'd4
    } state_e;

    localparam int unsigned AddrBytes = ADDR_W / 8;
    localparam int unsigned LenBytes  = LEN_W / 8;
    localparam logic [1:0]  AddrLast  = 2'(AddrBytes - 1);
    localparam logic [1:0]  LenLast   = 2'(LenBytes - 1);

    if ((ADDR_W % 8) != 0 || ADDR_W < 8 || ADDR_W > 32 ||
        (LEN_W % 8) != 0 || LEN_W < 8 || LEN_W > 32 || TIMEOUT_CYC == 0) begin : g_param_check
        $error("ftdi_order_decoder: unsupported parameter combination");
    end

    state_e            state_q;
    logic [1:0]        byte_idx_q;
    logic [ADDR_W-1:0] address_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [7:0]        value_q;
    logic [7:0]        err_count_q;
    logic              write_q;
    logic              is_read_q;
    logic              inc_q;

    logic              consume;
    logic              pop;
    logic              read_strobe;
    logic              strobe_done;
    logic              cmd_valid;
    logic              abort;
    logic [ADDR_W-1:0] addr_shift;
    logic [LEN_W-1:0]  cnt_shift;

    // WDATA stops consuming once cnt hits zero so the final write strobe is
    // issued while still busy, before the next header can be taken.
    always_comb begin
        consume = 1'b0;
        unique case (state_q)
            StIdle, StAddr, StLen: consume = 1'b1;
            StWdata:               consume = (cnt_q != '0);
            default:               consume = 1'b0;
        endcase
    end

    always_comb begin
        pop         = res_n & consume & ~bus.ri_empty;
        read_strobe = res_n & (state_q == StRissue) & (cnt_q != '0) & ~bus.rb_full;
        strobe_done = write_q | read_strobe;
        cmd_valid   = (bus.ri_data[7:6] == 2'b01) || (bus.ri_data[7:6] == 2'b10);
        addr_shift  = ADDR_W'({address_q, bus.ri_data});
        cnt_shift   = LEN_W'({cnt_q, bus.ri_data});
    end

`ifdef ORDER_DECODER_CMD_TIMEOUT_EN
    localparam int unsigned ToW = $clog2(TIMEOUT_CYC + 1);

    logic [ToW-1:0] idle_cnt_q;
    logic           timeout_err_q;
    logic           waiting;

    always_comb begin
        waiting = consume & bus.ri_empty &
                  ((state_q == StAddr) || (state_q == StLen) || (state_q == StWdata));
        abort   = waiting & (idle_cnt_q == ToW'(TIMEOUT_CYC - 1));
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            idle_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= abort;
            if (!waiting || abort) begin
                idle_cnt_q <= '0;
            end else begin
                idle_cnt_q <= idle_cnt_q + ToW'(1);
            end
        end
    end

    assign bus.timeout_err = timeout_err_q;
`else
    assign abort           = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!res_n) begin
            state_q     <= StIdle;
            byte_idx_q  <= '0;
            address_q   <= '0;
            cnt_q       <= '0;
            value_q     <= '0;
            err_count_q <= '0;
            write_q     <= 1'b0;
            is_read_q   <= 1'b0;
            inc_q       <= 1'b0;
        end else begin
            write_q <= 1'b0;
            // Address advances at the end of the cycle that carried the strobe.
            if (strobe_done && inc_q) begin
                address_q <= address_q + ADDR_W'(1);
            end
            if (read_strobe) begin
                cnt_q <= cnt_q - LEN_W'(1);
            end

            if (abort) begin
                state_q    <= StIdle;
                byte_idx_q <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (pop) begin
                            if (cmd_valid) begin
                                is_read_q  <= bus.ri_data[7];
                                inc_q      <= bus.ri_data[5];
                                byte_idx_q <= '0;
                                state_q    <= StAddr;
                            end else if (err_count_q != 8'hFF) begin
                                err_count_q <= err_count_q + 8'd1;
                            end
                        end
                    end
                    StAddr: begin
                        if (pop) begin
                            address_q <= addr_shift;
                            if (byte_idx_q == AddrLast) begin
                                byte_idx_q <= '0;
                                state_q    <= StLen;
                            end else begin
                                byte_idx_q <= byte_idx_q + 2'd1;
                            end
                        end
                    end
                    StLen: begin
                        if (pop) begin
                            cnt_q <= cnt_shift;
                            if (byte_idx_q == LenLast) begin
                                byte_idx_q <= '0;
                                if (cnt_shift == '0) begin
                                    state_q <= StIdle;
                                end else if (is_read_q) begin
                                    state_q <= StRissue;
                                end else begin
                                    state_q <= StWdata;
                                end
                            end else begin
                                byte_idx_q <= byte_idx_q + 2'd1;
                            end
                        end
                    end
                    StWdata: begin
                        if (cnt_q == '0) begin
                            state_q <= StIdle;
                        end else if (pop) begin
                            value_q <= bus.ri_data;
                            write_q <= 1'b1;
                            cnt_q   <= cnt_q - LEN_W'(1);
                        end
                    end
                    StRissue: begin
                        if (cnt_q == '0 || (read_strobe && cnt_q == LEN_W'(1))) begin
                            state_q <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign bus.ri_read   = pop;
    assign bus.read      = read_strobe;
    assign bus.write     = write_q;
    assign bus.address   = address_q;
    assign bus.value     = value_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.state     = state_q;
    assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_ftdi_order_decoder.sv
// Directed bench for ftdi_order_decoder: FWFT FIFO feeder, strobe logger, hand-computed checks.
module tb_ftdi_order_decoder;

    localparam int unsigned ADDR_W      = 8;
    localparam int unsigned LEN_W       = 16;
    localparam int unsigned TIMEOUT_CYC = 16;

    logic clk;
    logic res_n;

    ftdi_order_decoder_if #(.ADDR_W(ADDR_W)) bus ();

    ftdi_order_decoder #(
        .ADDR_W      (ADDR_W),
        .LEN_W       (LEN_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk   (clk),
        .res_n (res_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // FWFT read FIFO model: present front at negedge, pop if ri_read was high at the posedge.
    logic [7:0] fifo[$];
    logic       will_pop;

    initial begin
        bus.ri_data  = 8'h00;
        bus.ri_empty = 1'b1;
        will_pop     = 1'b0;
        forever begin
            @(negedge clk);
            if (will_pop && fifo.size() > 0) fifo.delete(0);
            bus.ri_empty = (fifo.size() == 0);
            bus.ri_data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
            #1 will_pop = bus.ri_read;
        end
    end

    // Strobe logger, sampled mid-low-phase.
    int unsigned cyc = 0;
    logic [7:0]  wr_addr[$];
    logic [7:0]  wr_data[$];
    int unsigned wr_cyc[$];
    logic [7:0]  rd_addr[$];
    int unsigned rd_cyc[$];
    int unsigned both_cnt = 0;
    int unsigned rd_full_cnt = 0;
    int unsigned to_pulses = 0;
    int unsigned busy_fall = 0;
    logic        prev_busy = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            #2;
            if (bus.write) begin
                wr_addr.push_back(bus.address);
                wr_data.push_back(bus.value);
                wr_cyc.push_back(cyc);
            end
            if (bus.read) begin
                rd_addr.push_back(bus.address);
                rd_cyc.push_back(cyc);
            end
            if (bus.write && bus.read) both_cnt++;
            if (bus.read && bus.rb_full) rd_full_cnt++;
            if (bus.timeout_err) to_pulses++;
            if (prev_busy && !bus.busy) busy_fall = cyc;
            prev_busy = bus.busy;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
    endtask

    task automatic clear_logs();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        rd_addr.delete();
        rd_cyc.delete();
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #3;
            if (fifo.size() == 0 && !bus.busy) break;
        end
        tick(2);
        #3;
        check("wait_idle_busy", {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        res_n        = 1'b0;
        bus.rb_full  = 1'b0;

        // Reset state, and no pop while reset is held even with data present.
        tick(3);
        push(8'h40);
        tick(2);
        #3;
        check("rst_state", {28'd0, bus.state}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_address", {24'd0, bus.address}, 32'd0);
        check("rst_value", {24'd0, bus.value}, 32'd0);
        check("rst_write", {31'd0, bus.write}, 32'd0);
        check("rst_read", {31'd0, bus.read}, 32'd0);
        check("rst_err_count", {24'd0, bus.err_count}, 32'd0);
        check("rst_timeout_err", {31'd0, bus.timeout_err}, 32'd0);
        check("rst_ri_read", {31'd0, bus.ri_read}, 32'd0);
        fifo.delete();
        tick(2);
        res_n = 1'b1;

        // Reset in the middle of a 5-byte write frame with only 2 data bytes delivered.
        push(8'h40); push(8'h12); push(8'h00); push(8'h05); push(8'h11); push(8'h22);
        tick(12);
        #3;
        check("midframe_state", {28'd0, bus.state}, 32'd3);
        check("midframe_writes", wr_addr.size(), 32'd2);
        res_n = 1'b0;
        tick(2);
        #3;
        check("midrst_state", {28'd0, bus.state}, 32'd0);
        tick(1);
        res_n = 1'b1;
        clear_logs();
        tick(5);
        check("post_rst_no_stale", wr_addr.size() + rd_addr.size(), 32'd0);
        push(8'h40); push(8'h12); push(8'h00); push(8'h01); push(8'hAB);
        wait_idle(50);
        check("post_rst_write_cnt", wr_addr.size(), 32'd1);
        if (wr_addr.size() == 1) begin
            check("post_rst_addr", {24'd0, wr_addr[0]}, 32'h12);
            check("post_rst_data", {24'd0, wr_data[0]}, 32'hAB);
        end

        // Incrementing write burst.
        clear_logs();
        push(8'h60); push(8'h10); push(8'h00); push(8'h03);
        push(8'h01); push(8'h02); push(8'h03);
        wait_idle(50);
        check("burst_write_cnt", wr_addr.size(), 32'd3);
        if (wr_addr.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("burst_addr%0d", i), {24'd0, wr_addr[i]}, 32'h10 + i);
                check($sformatf("burst_data%0d", i), {24'd0, wr_data[i]}, 32'h01 + i);
            end
            check("burst_b2b_1", wr_cyc[1] - wr_cyc[0], 32'd1);
            check("burst_b2b_2", wr_cyc[2] - wr_cyc[1], 32'd1);
            check("burst_busy_fall", busy_fall, wr_cyc[2] + 1);
        end
        check("burst_addr_after", {24'd0, bus.address}, 32'h13);

        // Fixed-address read with back-pressure on RISSUE cycles 2-5.
        clear_logs();
        push(8'h80); push(8'h20); push(8'h00); push(8'h04);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.state == 4'd4) break;
        end
        tick(1);
        bus.rb_full = 1'b1;
        tick(4);
        bus.rb_full = 1'b0;
        wait_idle(50);
        check("rd_cnt", rd_addr.size(), 32'd4);
        check("rd_no_writes", wr_addr.size(), 32'd0);
        check("rd_while_full", rd_full_cnt, 32'd0);
        if (rd_addr.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("rd_addr%0d", i), {24'd0, rd_addr[i]}, 32'h20);
            end
            check("rd_gap", rd_cyc[1] - rd_cyc[0], 32'd5);
            check("rd_last", rd_cyc[3] - rd_cyc[0], 32'd7);
        end

        // Address wrap, then zero-length frame.
        clear_logs();
        push(8'h60); push(8'hFF); push(8'h00); push(8'h02); push(8'h5A); push(8'hA5);
        wait_idle(50);
        check("wrap_cnt", wr_addr.size(), 32'd2);
        if (wr_addr.size() == 2) begin
            check("wrap_addr0", {24'd0, wr_addr[0]}, 32'hFF);
            check("wrap_addr1", {24'd0, wr_addr[1]}, 32'h00);
            check("wrap_data1", {24'd0, wr_data[1]}, 32'hA5);
        end
        clear_logs();
        push(8'h40); push(8'h33); push(8'h00); push(8'h00);
        wait_idle(50);
        check("zero_len_strobes", wr_addr.size() + rd_addr.size(), 32'd0);
        check("zero_len_state", {28'd0, bus.state}, 32'd0);
        check("zero_len_addr", {24'd0, bus.address}, 32'h33);

        // Invalid headers: saturating error count.
        clear_logs();
        for (int i = 0; i < 254; i++) push(8'h00);
        wait_idle(400);
        check("err_254", {24'd0, bus.err_count}, 32'd254);
        for (int i = 0; i < 46; i++) push(8'h00);
        wait_idle(400);
        check("err_sat", {24'd0, bus.err_count}, 32'd255);
        check("err_no_strobes", wr_addr.size() + rd_addr.size(), 32'd0);
        push(8'h40); push(8'h44); push(8'h00); push(8'h01); push(8'h99);
        wait_idle(50);
        check("err_then_valid_cnt", wr_addr.size(), 32'd1);
        if (wr_addr.size() == 1) begin
            check("err_then_valid_addr", {24'd0, wr_addr[0]}, 32'h44);
            check("err_then_valid_data", {24'd0, wr_data[0]}, 32'h99);
        end

        // Input starvation inside a frame.
        clear_logs();
        push(8'h40); push(8'h55);
`ifdef ORDER_DECODER_CMD_TIMEOUT_EN
        begin
            int waited;
            waited = 60;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                #3;
                if (to_pulses != 0) begin
                    waited = i;
                    break;
                end
            end
            tick(3);
            #3;
            check("to_pulse_cnt", to_pulses, 32'd1);
            check("to_window", {31'd0, (waited >= 16 && waited <= 22)}, 32'd1);
            check("to_state", {28'd0, bus.state}, 32'd0);
            check("to_no_strobes", wr_addr.size(), 32'd0);
        end
        push(8'h40); push(8'h66); push(8'h00); push(8'h01); push(8'h77);
        wait_idle(50);
        check("to_next_cnt", wr_addr.size(), 32'd1);
        if (wr_addr.size() == 1) begin
            check("to_next_addr", {24'd0, wr_addr[0]}, 32'h66);
            check("to_next_data", {24'd0, wr_data[0]}, 32'h77);
        end
`else
        tick(30);
        #3;
        check("stall_state", {28'd0, bus.state}, 32'd2);
        check("stall_no_timeout", to_pulses, 32'd0);
        push(8'h00); push(8'h01); push(8'h77);
        wait_idle(50);
        check("stall_resume_cnt", wr_addr.size(), 32'd1);
        if (wr_addr.size() == 1) begin
            check("stall_resume_addr", {24'd0, wr_addr[0]}, 32'h55);
            check("stall_resume_data", {24'd0, wr_data[0]}, 32'h77);
        end
`endif

        check("wr_rd_exclusive", both_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ftdi_order_decoder.md
Name: ftdi_order_decoder

Overview:
Parametrised successor to the byte-stream order sorter between the FTDI read FIFO and the register file.
- Parses host frames: header, multi-byte address, multi-byte length, optional payload.
- Emits single-cycle read/write strobes to the register file.
- Adds what the fixed 8-bit sorter lacks: configurable address/length widths, address auto-increment bursts, readback back-pressure, malformed-header error counting.
- Sits in clk domain, between the read-side async FIFO (first-word-fall-through) and the RegisterFile.

Parameters:
ADDR_W, 8, address width in bits; multiple of 8, range 8..32; sent as ADDR_W/8 bytes, MSB first.
LEN_W, 16, length field width in bits; multiple of 8, range 8..32; sent as LEN_W/8 bytes, MSB first.
TIMEOUT_CYC, 4096, idle-input cycles tolerated inside a frame before abort (only with CMD_TIMEOUT_EN).

Ports:
clk  in  1  system clock; single clock domain.
res_n  in  1  reset, synchronous, active-low.
ri_data  in  8  FWFT read FIFO data; valid while ri_empty=0.
ri_empty  in  1  read FIFO empty.
ri_read  out  1  pop strobe; combinational = consuming state & ~ri_empty.
rb_full  in  1  readback (write-to-FTDI) FIFO prog_full.
address  out  ADDR_W  register address for the current strobe.
value  out  8  write data.
write  out  1  one-cycle write strobe.
read  out  1  one-cycle read strobe.
busy  out  1  high whenever state != IDLE.
state  out  4  current FSM state code, for debug.
err_count  out  8  saturating count of rejected headers.
timeout_err  out  1  one-cycle pulse on frame abort (0 if CMD_TIMEOUT_EN undefined).

Behaviour:
- Reset (res_n=0 at clk edge):
  - state=IDLE; address=0, value=0, write=0, read=0; err_count=0, timeout_err=0.
  - Internal byte and length counters cleared; any in-flight frame discarded.
  - ri_read=0 while res_n=0.
- Header byte fields:
  - [7:6] command: 01=WRITE, 10=READ, 00/11=invalid.
  - [5] INC: 1 = address increments after each strobe; 0 = fixed address (FIFO-style register).
  - [4:0] ignored.
- State codes: IDLE=0, ADDR=1, LEN=2, WDATA=3, RISSUE=4.
- IDLE:
  - Consumes one byte when ~ri_empty.
  - Valid command: latch cmd/INC, go to ADDR.
  - Invalid command: err_count += 1 (saturate at 255), stay in IDLE.
- ADDR: consumes ADDR_W/8 bytes, shifted into the address register MSB first, then goes to LEN.
- LEN:
  - Consumes LEN_W/8 bytes into cnt, MSB first.
  - On the last byte:
    - cnt==0: return to IDLE; no strobes.
    - WRITE: go to WDATA.
    - READ: go to RISSUE.
- WDATA (per consumed byte):
  - Next cycle: value=byte, write=1 with current address (latency 1 from ri_read).
  - cnt decrements.
  - Address increments after the strobe if INC=1.
  - After the strobe for cnt==1, go to IDLE. Back-to-back bytes give back-to-back write strobes.
- RISSUE:
  - Each cycle with rb_full=0: read=1, cnt decrements, address increments after the strobe if INC=1.
  - rb_full=1: no strobe, hold.
  - After the last strobe, go to IDLE.
  - ri_read=0 throughout RISSUE; no input bytes consumed.
- Address wraps modulo 2^ADDR_W on increment. Length up to 2^LEN_W-1.
- write and read are never high in the same cycle.
- ri_empty=1 mid-frame: FSM waits; no timeout unless CMD_TIMEOUT_EN is defined.

Optional Feature:
Macro: ORDER_DECODER_CMD_TIMEOUT_EN.
- Defined:
  - Counter runs in ADDR, LEN or WDATA while ri_empty=1; cleared on every consumed byte and in IDLE/RISSUE.
  - On reaching TIMEOUT_CYC: pulse timeout_err 1 cycle, return to IDLE, no further strobes for that frame.
- Undefined: counter absent; timeout_err tied 0; FSM waits indefinitely.

Test Plan:
- Reset: apply res_n=0 mid-WDATA frame, release, send 0x40,0x12,0x00,0x01,0xAB -> no stale strobes; exactly one write with address=0x12, value=0xAB.
- Write burst: header 0x60, addr 0x10, len 0x0003, data 0x01,0x02,0x03 -> writes at 0x10/0x11/0x12 with 0x01/0x02/0x03 on consecutive cycles; busy drops after the third.
- Fixed-address read with back-pressure: header 0x80, addr 0x20, len 0x0004, rb_full high for cycles 2-5 -> exactly 4 read strobes, all at address 0x20, none while rb_full=1.
- Wrap and zero length: header 0x60, addr 0xFF, len 2 -> writes at 0xFF then 0x00. Frame with len 0 -> no strobes, IDLE after the length bytes.
- Invalid headers: 300 bytes of 0x00 -> err_count saturates at 255, no strobes; a following valid frame still executes.
- Timeout (macro defined, TIMEOUT_CYC=16): header 0x40, one address byte, then FIFO empty 16 cycles -> timeout_err pulse, state=0; the next frame decodes correctly.
